// File: rtl/uart_hex_if.sv
// Request/serial bundle between the calculator execution unit and the hex UART stage.
// valid/ready: a request transfers on a rising clk edge where send_vld && send_rdy.
interface uart_hex_if;
    logic       send_vld;
    logic [7:0] send_data;
    logic       send_rdy;
    logic       tx;
    logic       busy;
    logic [1:0] fsm_state;

    modport master (
        output send_vld, send_data,
        input  send_rdy, tx, busy, fsm_state
    );

    modport slave (
        input  send_vld, send_data,
        output send_rdy, tx, busy, fsm_state
    );
endinterface

// File: rtl/uart_hex_tx.sv
// Formats an 8-bit value as two uppercase hex ASCII characters plus CR LF and
// shifts the four bytes out as back-to-back 8N1 frames on tx.
module uart_hex_tx #(
    parameter int CLK_DIV = 100
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_hex_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_next;
    logic [15:0] div_cnt, div_next;
    logic [2:0]  bit_cnt, bit_next;
    logic [1:0]  byte_idx, idx_next;
    logic [7:0]  data_q, data_next;
    logic        tx_q, tx_next;
    logic        accept;
    logic        wrap;
    logic [7:0]  cur_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign accept = bus.send_vld && (state == IDLE);
    assign wrap   = (div_cnt == 16'(CLK_DIV - 1));

    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        idx_next   = byte_idx;
        data_next  = data_q;
        case (state)
            IDLE: begin
                div_next = 16'd0;
                if (accept) begin
                    state_next = START;
                    idx_next   = 2'd0;
                    data_next  = bus.send_data;
                end
            end
            START: begin
                div_next = wrap ? 16'd0 : div_cnt + 16'd1;
                if (wrap) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                div_next = wrap ? 16'd0 : div_cnt + 16'd1;
                if (wrap) begin
                    if (bit_cnt == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_cnt + 3'd1;
                end
            end
            STOP: begin
                div_next = wrap ? 16'd0 : div_cnt + 16'd1;
                if (wrap) begin
                    if (byte_idx < 2'd3) begin
                        idx_next   = byte_idx + 2'd1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the next-cycle view so the line changes on the same
    // edge as the state it belongs to.
    always_comb begin
        cur_byte = 8'h0A;
        case (idx_next)
            2'd0:    cur_byte = hex_char(data_next[7:4]);
            2'd1:    cur_byte = hex_char(data_next[3:0]);
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_byte[bit_next];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= 16'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            data_q   <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            byte_idx <= idx_next;
            data_q   <= data_next;
            tx_q     <= tx_next;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.send_rdy  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.fsm_state = state;

endmodule

// File: doc/uart_hex_tx.md
# uart_hex_tx

Downstream output stage of the nexys3 calculator. It accepts an 8-bit register value from the execution unit whenever a SEND instruction retires. It formats the value as two uppercase ASCII hex characters followed by CR LF, and serializes those four bytes on RsTx as 8N1 UART frames. The board-level UART model (1 Mbaud) consumes this output.

## Interface
- CLK_DIV, default 100, clock cycles per UART bit (100 MHz clk / 1 Mbaud); legal range 2..65535.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
- send_vld  input  1  one-cycle request: send_data is a value to transmit.
- send_data  input  8  register value to format and send.
- send_rdy  output  1  high when the block can accept a request; a request is accepted when send_vld && send_rdy.
- tx  output  1  UART serial line to RsTx; idle high.
- busy  output  1  high while any of the 4 bytes is in flight (equals ~send_rdy).

## Operation
- Reset (rst_n=0 at a clk edge) forces these values from the next cycle: tx=1, send_rdy=1, busy=0, FSM=IDLE, bit counter=0, byte index=0, divider=0.
- On accept, latch send_data into a holding register. Build the byte sequence b0=hex(data[7:4]), b1=hex(data[3:0]), b2=0x0D, b3=0x0A.
- hex(n): n 0..9 maps to 0x30+n; n 10..15 maps to 0x41+(n-10). Output is uppercase only.
- FSM states:
  - IDLE: tx=1, send_rdy=1. On accept, go to START with byte index 0.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit 0.
  - DATA: tx=current byte[bit], LSB first. Hold each bit for CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. If byte index < 3, increment it and go to START. Otherwise go to IDLE.
- The divider counts 0..CLK_DIV-1 and wraps. A state or bit advances only on the wrap.
- send_vld while send_rdy=0 is ignored and dropped, with no queueing. The holding register is not disturbed mid-transfer.
- send_data is sampled only in the accept cycle. Changes after that have no effect.
- Reset mid-transfer aborts immediately. No partial-frame completion, and tx returns to 1.

## Timing
- Accept at edge N: send_rdy=0 and tx=0 (start bit of b0) from cycle N+1.
- Each frame is exactly 10*CLK_DIV cycles: start, 8 data bits, stop. Frames follow back-to-back with no idle gap.
- Full transfer is 40*CLK_DIV cycles. send_rdy returns to 1 in the cycle after the last stop bit completes, i.e. cycle N+1+40*CLK_DIV.
- A request in the same cycle send_rdy rises is accepted. The minimum request spacing is 40*CLK_DIV+1 cycles.
- tx is driven from a register, so it has no combinational path from inputs.
- If send_vld and rst_n=0 occur in the same cycle, reset wins and the request is dropped.

## Test plan
- Reset check: hold rst_n=0 for 5 cycles, then release. Require tx=1, send_rdy=1, busy=0 throughout and for 10 cycles after release.
- Basic send: send_data=0x08 with CLK_DIV=100. Decode tx and require bytes 0x30, 0x38, 0x0D, 0x0A. send_rdy must be low for exactly 4000 cycles.
- Hex letters: send_data=0xAF gives 0x41, 0x46, 0x0D, 0x0A. send_data=0x00 gives 0x30, 0x30. send_data=0xFF gives 0x46, 0x46.
- Bit timing: on each start edge, tx must stay low for exactly CLK_DIV cycles. The stop bit must be high for exactly CLK_DIV cycles. Repeat with CLK_DIV=2 for the minimum case.
- Drop while busy: send 0x12, then pulse send_vld with 0x34 at cycle +500. Only 0x31, 0x32, 0x0D, 0x0A appears. An immediate resend of 0x34 after send_rdy rises is accepted and transmitted correctly.
- Reset mid-transfer: assert rst_n=0 during DATA of b1. Next cycle requires tx=1 and send_rdy=1. A following send of 0x5C yields 0x35, 0x43, 0x0D, 0x0A cleanly.
